// File: rtl/sw_input_cond.sv
// Switch input conditioning: 2-flop synchroniser, per-bit debounce, clean levels, edge pulses,
// rate-change strobe on sw_clean[3:2]. Optional per-bit auto-repeat under macro SW_REPEAT_EN.
module sw_input_cond #(
  parameter int N_SW       = 4,
  parameter int DB_CNT     = 50000,
  parameter int CNT_W      = 16,
  parameter int REPEAT_CYC = 2500000
) (
  input  logic            clk_in,
  input  logic            rst_n,
  input  logic [N_SW-1:0] sw_raw,
  output logic [N_SW-1:0] sw_clean,
  output logic [N_SW-1:0] sw_rise,
  output logic [N_SW-1:0] sw_fall,
  output logic            rate_chg,
  output logic [N_SW-1:0] sw_rep
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CNT - 1);

  logic [N_SW-1:0]  sync_p0;
  logic [N_SW-1:0]  sync_p1;
  logic [CNT_W-1:0] cnt [N_SW];
  logic [N_SW-1:0]  toggle;
  logic [N_SW-1:0]  clean_next;

  // Stage p0/p1: metastability chain on the raw asynchronous switches
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= sw_raw;
      sync_p1 <= sync_p0;
    end
  end

  always_comb begin
    toggle     = '0;
    clean_next = sw_clean;
    for (int i = 0; i < N_SW; i++) begin
      toggle[i] = (sync_p1[i] != sw_clean[i]) && (cnt[i] == DB_LAST);
    end
    clean_next = sw_clean ^ toggle;
  end

  // Debounce: count consecutive cycles of disagreement; any agreement restarts the count
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_SW; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_SW; i++) begin
        if ((sync_p1[i] == sw_clean[i]) || toggle[i]) cnt[i] <= '0;
        else                                           cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sw_clean <= '0;
      sw_rise  <= '0;
      sw_fall  <= '0;
    end else begin
      sw_clean <= clean_next;
      sw_rise  <= toggle & ~sw_clean;
      sw_fall  <= toggle & sw_clean;
    end
  end

  generate
    if (N_SW >= 4) begin : g_rate
      // One pulse even when bits 3 and 2 flip together
      always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) rate_chg <= 1'b0;
        else        rate_chg <= |toggle[3:2];
      end
    end else begin : g_no_rate
      assign rate_chg = 1'b0;
    end
  endgenerate

`ifdef SW_REPEAT_EN
  localparam int REP_W = (REPEAT_CYC > 1) ? $clog2(REPEAT_CYC) : 1;
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYC - 1);

  logic [REP_W-1:0] rep_cnt [N_SW];
  logic [N_SW-1:0]  rise_next;

  assign rise_next = toggle & ~sw_clean;

  // Counter restarts on the rise cycle so the first repeat lands REPEAT_CYC after sw_rise
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_SW; i++) rep_cnt[i] <= '0;
      sw_rep <= '0;
    end else begin
      for (int i = 0; i < N_SW; i++) begin
        if (!clean_next[i] || rise_next[i]) begin
          rep_cnt[i] <= '0;
          sw_rep[i]  <= 1'b0;
        end else if (rep_cnt[i] == REP_LAST) begin
          rep_cnt[i] <= '0;
          sw_rep[i]  <= 1'b1;
        end else begin
          rep_cnt[i] <= rep_cnt[i] + 1'b1;
          sw_rep[i]  <= 1'b0;
        end
      end
    end
  end
`else
  assign sw_rep = '0;
`endif

endmodule

// File: tb/tb_sw_input_cond.sv
// Directed bench for sw_input_cond with N_SW=4, DB_CNT=4, REPEAT_CYC=8.
module tb_sw_input_cond;

  logic       clk_in = 1'b0;
  logic       rst_n;
  logic [3:0] sw_raw;
  logic [3:0] sw_clean, sw_rise, sw_fall, sw_rep;
  logic       rate_chg;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0] raw;
    logic [3:0] clean;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       rate;
  } vec_t;

  vec_t tbl[$];

  sw_input_cond #(.N_SW(4), .DB_CNT(4), .CNT_W(4), .REPEAT_CYC(8)) dut (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .sw_raw  (sw_raw),
    .sw_clean(sw_clean),
    .sw_rise (sw_rise),
    .sw_fall (sw_fall),
    .rate_chg(rate_chg),
    .sw_rep  (sw_rep)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #2;
  endtask

  task automatic do_reset(input logic [3:0] raw);
    rst_n  = 1'b0;
    sw_raw = raw;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Five cycles holding the old level, then the cycle where the new level and pulses appear
  function automatic void phase(input logic [3:0] raw, input logic [3:0] old_c,
                                input logic [3:0] new_c, input logic [3:0] rise,
                                input logic [3:0] fall, input logic rate);
    for (int k = 0; k < 5; k++) tbl.push_back('{raw, old_c, 4'h0, 4'h0, 1'b0});
    tbl.push_back('{raw, new_c, rise, fall, rate});
  endfunction

  initial begin
    logic [3:0] exp_rep;

    phase(4'hF, 4'h0, 4'hF, 4'hF, 4'h0, 1'b1);
    phase(4'h3, 4'hF, 4'h3, 4'h0, 4'hC, 1'b1);
    phase(4'h2, 4'h3, 4'h2, 4'h0, 4'h1, 1'b0);
    phase(4'h3, 4'h2, 4'h3, 4'h1, 4'h0, 1'b0);
    phase(4'h7, 4'h3, 4'h7, 4'h4, 4'h0, 1'b1);
    phase(4'hB, 4'h7, 4'hB, 4'h8, 4'h4, 1'b1);
    tbl.push_back('{4'hB, 4'hB, 4'h0, 4'h0, 1'b0});
    tbl.push_back('{4'hB, 4'hB, 4'h0, 4'h0, 1'b0});

    // Reset with all switches high: everything held at zero
    rst_n  = 1'b0;
    sw_raw = 4'hF;
    step();
    step();
    chk("rst_clean", {28'h0, sw_clean}, 32'h0);
    chk("rst_rise",  {28'h0, sw_rise},  32'h0);
    chk("rst_fall",  {28'h0, sw_fall},  32'h0);
    chk("rst_rate",  {31'h0, rate_chg}, 32'h0);
    chk("rst_rep",   {28'h0, sw_rep},   32'h0);
    rst_n = 1'b1;

    foreach (tbl[j]) begin
      sw_raw = tbl[j].raw;
      step();
      chk($sformatf("tbl%0d_clean", j), {28'h0, sw_clean}, {28'h0, tbl[j].clean});
      chk($sformatf("tbl%0d_rise", j),  {28'h0, sw_rise},  {28'h0, tbl[j].rise});
      chk($sformatf("tbl%0d_fall", j),  {28'h0, sw_fall},  {28'h0, tbl[j].fall});
      chk($sformatf("tbl%0d_rate", j),  {31'h0, rate_chg}, {31'h0, tbl[j].rate});
`ifndef SW_REPEAT_EN
      chk($sformatf("tbl%0d_rep", j),   {28'h0, sw_rep},   32'h0);
`endif
    end

    // Bounce on bit 1: pulses of 2 cycles never reach the debounce count
    do_reset(4'h0);
    for (int k = 0; k < 8; k++) step();
    for (int b = 0; b < 4; b++) begin
      sw_raw = (b % 2 == 0) ? 4'h2 : 4'h0;
      for (int k = 0; k < 2; k++) begin
        step();
        chk("bounce_clean", {28'h0, sw_clean}, 32'h0);
        chk("bounce_pulse", {24'h0, sw_rise, sw_fall}, 32'h0);
      end
    end
    for (int k = 0; k < 6; k++) begin
      step();
      chk("bounce_settle", {28'h0, sw_clean | sw_rise | sw_fall}, 32'h0);
    end
    sw_raw = 4'h2;
    for (int k = 1; k <= 7; k++) begin
      step();
      chk($sformatf("hold1_clean_t%0d", k), {28'h0, sw_clean}, (k >= 6) ? 32'h2 : 32'h0);
      chk($sformatf("hold1_rise_t%0d", k),  {28'h0, sw_rise},  (k == 6) ? 32'h2 : 32'h0);
    end

    // Asynchronous reset in the middle of a count on bit 0, with bit 2 already clean-high
    do_reset(4'h4);
    for (int k = 0; k < 7; k++) step();
    chk("mid_pre_clean", {28'h0, sw_clean}, 32'h4);
    sw_raw = 4'h5;
    for (int k = 0; k < 4; k++) step();
    chk("mid_cnt_before", {28'h0, dut.cnt[0]}, 32'h2);
    rst_n = 1'b0;
    #1;
    chk("mid_cnt_after",   {28'h0, dut.cnt[0]}, 32'h0);
    chk("mid_clean_after", {28'h0, sw_clean},   32'h0);
    step();
    step();
    rst_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk($sformatf("mid_clean_t%0d", k), {28'h0, sw_clean}, (k == 6) ? 32'h5 : 32'h0);
      chk($sformatf("mid_rise_t%0d", k),  {28'h0, sw_rise},  (k == 6) ? 32'h5 : 32'h0);
      chk($sformatf("mid_rate_t%0d", k),  {31'h0, rate_chg}, (k == 6) ? 32'h1 : 32'h0);
    end

    // Hold bit 0 for 30 cycles: rise at +6, repeats at rise+8/16/24, fall at +36
    do_reset(4'h0);
    for (int k = 0; k < 8; k++) step();
    sw_raw = 4'h1;
    for (int k = 1; k <= 45; k++) begin
      if (k == 31) sw_raw = 4'h0;
      step();
`ifdef SW_REPEAT_EN
      exp_rep = (k == 14 || k == 22 || k == 30) ? 4'h1 : 4'h0;
`else
      exp_rep = 4'h0;
`endif
      chk($sformatf("rep_t%0d", k),  {28'h0, sw_rep},  {28'h0, exp_rep});
      chk($sformatf("rise_t%0d", k), {28'h0, sw_rise}, (k == 6) ? 32'h1 : 32'h0);
      chk($sformatf("fall_t%0d", k), {28'h0, sw_fall}, (k == 36) ? 32'h1 : 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
